// File: rtl/mult_writeback_buffer.sv
// Writeback buffer: in-order queue between the multiplier result port and a register-file write port.
// Define MULT_WB_FORWARD_EN to add a register lookup that forwards the youngest queued result.
module mult_writeback_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] mul_result,
  input  logic [4:0]  mul_tag,
  input  logic        wb_ready,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic [4:0]  count,
  output logic        full,
  output logic        overflow
`ifdef MULT_WB_FORWARD_EN
  ,
  input  logic [4:0]  lookup_reg,
  output logic        lookup_hit,
  output logic [31:0] lookup_data
`endif
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam logic [4:0]  DepthCnt = 5'(DEPTH);

  logic [31:0]     data_mem [DEPTH];
  logic [4:0]      tag_mem  [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, drop;

  always_comb begin
    wb_valid = (count_q != 5'd0);
    full     = (count_q == DepthCnt);
    pop      = wb_valid && wb_ready;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    push     = (mul_tag != 5'd0) && (!full || pop);
    drop     = (mul_tag != 5'd0) && full && !pop;

    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    overflow_d = overflow_q || drop;

    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; stale entries are masked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mul_result;
      tag_mem[wr_ptr_q]  <= mul_tag;
    end
  end

  always_comb begin
    wb_data  = wb_valid ? data_mem[rd_ptr_q] : 32'd0;
    wb_reg   = wb_valid ? tag_mem[rd_ptr_q]  : 5'd0;
    count    = count_q;
    overflow = overflow_q;
  end

`ifdef MULT_WB_FORWARD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((5'(i) < count_q) && (lookup_reg != 5'd0) &&
          (tag_mem[rd_ptr_q + PtrW'(i)] == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[rd_ptr_q + PtrW'(i)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_writeback_buffer.sv
// Bench for mult_writeback_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mult_writeback_buffer;

  localparam int Depth = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] mul_result;
  logic [4:0]  mul_tag;
  logic        wb_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic [4:0]  count;
  logic        full;
  logic        overflow;
`ifdef MULT_WB_FORWARD_EN
  logic [4:0]  lookup_reg;
  logic        lookup_hit;
  logic [31:0] lookup_data;
`endif

  mult_writeback_buffer #(.DEPTH(Depth)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mul_result (mul_result),
    .mul_tag    (mul_tag),
    .wb_ready   (wb_ready),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_reg     (wb_reg),
    .count      (count),
    .full       (full),
    .overflow   (overflow)
`ifdef MULT_WB_FORWARD_EN
    ,
    .lookup_reg  (lookup_reg),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
  } ent_t;

  ent_t model_q[$];
  bit   model_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue with a capacity limit and a sticky drop flag.
  always @(posedge clock) begin
    if (!reset_n) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      bit was_full;
      bit popped;
      was_full = (model_q.size() == Depth);
      popped   = (model_q.size() > 0) && wb_ready;
      if (popped) void'(model_q.pop_front());
      if (mul_tag != 5'd0) begin
        if (!was_full || popped) model_q.push_back('{tag: mul_tag, data: mul_result});
        else model_ovf = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      int n;
      n = model_q.size();
      check("m_valid", 32'(wb_valid), 32'(n != 0));
      check("m_count", 32'(count), 32'(n));
      check("m_full", 32'(full), 32'(n == Depth));
      check("m_overflow", 32'(overflow), 32'(model_ovf));
      check("m_reg", 32'(wb_reg), (n != 0) ? 32'(model_q[0].tag) : 32'd0);
      check("m_data", wb_data, (n != 0) ? model_q[0].data : 32'd0);
`ifdef MULT_WB_FORWARD_EN
      begin
        bit          hit;
        logic [31:0] fwd;
        hit = 1'b0;
        fwd = 32'd0;
        foreach (model_q[k]) begin
          if (lookup_reg != 5'd0 && model_q[k].tag == lookup_reg) begin
            hit = 1'b1;
            fwd = model_q[k].data;
          end
        end
        check("m_lookup_hit", 32'(lookup_hit), 32'(hit));
        check("m_lookup_data", lookup_data, fwd);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] t, input logic [31:0] d, input logic r);
    mul_tag    = t;
    mul_result = d;
    wb_ready   = r;
    tick();
  endtask

  task automatic do_reset();
    mul_tag = 5'd0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int exp34[4];
    reset_n    = 1'b0;
    mul_tag    = 5'd0;
    mul_result = 32'd0;
    wb_ready   = 1'b0;
`ifdef MULT_WB_FORWARD_EN
    lookup_reg = 5'd0;
`endif
    tick();
    tick();
    reset_n  = 1'b1;
    checking = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_full", 32'(full), 32'd0);

    // Single result through an empty queue.
    drive(5'd5, 32'h0000_0C00, 1'b1);
    check("single_valid", 32'(wb_valid), 32'd1);
    check("single_reg", 32'(wb_reg), 32'd5);
    check("single_data", wb_data, 32'h0000_0C00);
    drive(5'd0, 32'd0, 1'b1);
    check("single_drained_valid", 32'(wb_valid), 32'd0);
    check("single_drained_count", 32'(count), 32'd0);
    check("single_drained_data", wb_data, 32'd0);

    // Zero tag must never enqueue.
    for (int i = 0; i < 10; i++) drive(5'd0, 32'hFFFF_FFFF, 1'b1);
    check("zero_tag_valid", 32'(wb_valid), 32'd0);
    check("zero_tag_count", 32'(count), 32'd0);

    // Fill, overflow drop, then in-order drain.
    for (int t = 1; t <= 4; t++) drive(5'(t), 32'h1000_0000 | 32'(t), 1'b0);
    drive(5'd6, 32'h1000_0006, 1'b0);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int t = 1; t <= 4; t++) begin
      check("ovf_drain_reg", 32'(wb_reg), 32'(t));
      check("ovf_drain_data", wb_data, 32'h1000_0000 | 32'(t));
      drive(5'd0, 32'd0, 1'b1);
    end
    check("ovf_drain_empty", 32'(wb_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Push while full with a simultaneous pop.
    do_reset();
    check("clr_overflow", 32'(overflow), 32'd0);
    for (int t = 1; t <= 4; t++) drive(5'(t), 32'h2000_0000 | 32'(t), 1'b0);
    drive(5'd7, 32'h2000_0007, 1'b1);
    check("fullpp_count", 32'(count), 32'd4);
    check("fullpp_overflow", 32'(overflow), 32'd0);
    check("fullpp_full", 32'(full), 32'd1);
    exp34 = '{2, 3, 4, 7};
    for (int k = 0; k < 4; k++) begin
      check("fullpp_order", 32'(wb_reg), 32'(exp34[k]));
      drive(5'd0, 32'd0, 1'b1);
    end
    check("fullpp_empty", 32'(count), 32'd0);

    // Zero tag while full, then build an overflowed 3-entry queue and reset over a push.
    for (int t = 1; t <= 4; t++) drive(5'(t), 32'h3000_0000 | 32'(t), 1'b0);
    for (int i = 0; i < 3; i++) drive(5'd0, 32'hFFFF_FFFF, 1'b0);
    check("zero_full_count", 32'(count), 32'd4);
    check("zero_full_overflow", 32'(overflow), 32'd0);
    check("zero_full_head", 32'(wb_reg), 32'd1);
    drive(5'd6, 32'h3000_0006, 1'b0);
    drive(5'd0, 32'd0, 1'b1);
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    reset_n    = 1'b0;
    mul_tag    = 5'd8;
    mul_result = 32'h0000_0888;
    wb_ready   = 1'b1;
    tick();
    reset_n = 1'b1;
    mul_tag = 5'd0;
    check("rst_push_count", 32'(count), 32'd0);
    check("rst_push_valid", 32'(wb_valid), 32'd0);
    check("rst_push_overflow", 32'(overflow), 32'd0);

    // Mixed traffic to exercise pointer wrap and backpressure.
    for (int i = 0; i < 60; i++) begin
      drive(5'((i * 11) % 32), 32'(i) * 32'h0101_0101, ((i / 6) % 2 == 0) || (i % 3 == 0));
    end
    for (int i = 0; i <= Depth; i++) drive(5'd0, 32'd0, 1'b1);
    check("mixed_empty", 32'(count), 32'd0);

`ifdef MULT_WB_FORWARD_EN
    do_reset();
    drive(5'd9, 32'h11, 1'b0);
    drive(5'd9, 32'h22, 1'b0);
    drive(5'd3, 32'h33, 1'b0);
    mul_tag    = 5'd0;
    lookup_reg = 5'd9;
    #1;
    check("fwd_hit", 32'(lookup_hit), 32'd1);
    check("fwd_data", lookup_data, 32'h22);
    tick();
    lookup_reg = 5'd0;
    #1;
    check("fwd_zero_hit", 32'(lookup_hit), 32'd0);
    check("fwd_zero_data", lookup_data, 32'd0);
    lookup_reg = 5'd4;
    #1;
    check("fwd_miss_hit", 32'(lookup_hit), 32'd0);
    tick();
    lookup_reg = 5'd0;
`endif

    tick();
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
